// File: rtl/frequency_gate_sequencer_pkg.sv
// rtl/frequency_gate_sequencer_pkg.sv - shared states, range encoding and decimal-point masks
package frequency_gate_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_LATCH,
        ST_HOLD
    } state_t;

    typedef logic [1:0] range_t;

    localparam range_t RANGE_0 = 2'd0;
    localparam range_t RANGE_1 = 2'd1;
    localparam range_t RANGE_2 = 2'd2;

    localparam logic [7:0] DP_RANGE_0 = 8'b0001_0000;
    localparam logic [7:0] DP_RANGE_1 = 8'b0010_0000;
    localparam logic [7:0] DP_RANGE_2 = 8'b0100_0000;

    // Smallest interval counter that still covers a 1 s gate at 100 MHz.
    localparam int unsigned MIN_TIMER_WIDTH = 27;

    // The unused fourth encoding selects the longest gate.
    function automatic range_t clamp_range(input logic [1:0] sel);
        return (sel == 2'd3) ? RANGE_2 : sel;
    endfunction

    function automatic logic [7:0] dp_mask(input range_t r);
        case (r)
            RANGE_0: return DP_RANGE_0;
            RANGE_1: return DP_RANGE_1;
            default: return DP_RANGE_2;
        endcase
    endfunction

endpackage

// File: rtl/frequency_gate_sequencer_gate_timer.sv
// rtl/frequency_gate_sequencer_gate_timer.sv - loadable down-counter that flags the last cycle of an interval
module frequency_gate_sequencer_gate_timer
    import frequency_gate_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = MIN_TIMER_WIDTH
) (
    input  logic             reference_clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] remaining;

    // Load N on the edge that enters an interval; done is then high in its Nth cycle.
    always_ff @(posedge reference_clock) begin
        if (reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_value;
        end else if (remaining != '0) begin
            remaining <= remaining - WIDTH'(1);
        end
    end

    assign done = (remaining == WIDTH'(1));

endmodule

// File: rtl/frequency_gate_sequencer.sv
// rtl/frequency_gate_sequencer.sv - gated frequency counter sequencer; FREQUENCY_GATE_SEQUENCER_AUTORANGE_EN enables autoranging
module frequency_gate_sequencer
    import frequency_gate_sequencer_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = 36,
    parameter int unsigned GATE_CYCLES_0 = 1000000,
    parameter int unsigned GATE_CYCLES_1 = 10000000,
    parameter int unsigned GATE_CYCLES_2 = 100000000,
    parameter int unsigned CLEAR_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOW_THRESHOLD = 10000
) (
    input  logic                   reference_clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [1:0]             range_sel,
    input  logic [COUNT_WIDTH-1:0] count_in,
    input  logic                   result_ack,
    output logic                   gate,
    output logic                   clear_strobe,
    output logic                   latch_strobe,
    output logic [COUNT_WIDTH-1:0] result,
    output logic                   result_valid,
    output logic [1:0]             result_range,
    output logic                   result_overflow,
    output logic [7:0]             dp,
    output logic                   busy
);

    localparam int unsigned MAX_GATE_01 = (GATE_CYCLES_0 > GATE_CYCLES_1) ? GATE_CYCLES_0 : GATE_CYCLES_1;
    localparam int unsigned MAX_GATE    = (MAX_GATE_01 > GATE_CYCLES_2) ? MAX_GATE_01 : GATE_CYCLES_2;
    localparam int unsigned GATE_BITS   = $clog2(MAX_GATE + 1);
    localparam int unsigned TIMER_WIDTH = (GATE_BITS > MIN_TIMER_WIDTH) ? GATE_BITS : MIN_TIMER_WIDTH;

    typedef logic [TIMER_WIDTH-1:0] tcount_t;

    function automatic tcount_t gate_length(input range_t r);
        case (r)
            RANGE_0: return tcount_t'(GATE_CYCLES_0);
            RANGE_1: return tcount_t'(GATE_CYCLES_1);
            default: return tcount_t'(GATE_CYCLES_2);
        endcase
    endfunction

    state_t  state;
    range_t  active_range;
    range_t  start_range;
    range_t  auto_next_range;
    logic    count_all_ones;
    logic    timer_load;
    tcount_t timer_value;
    logic    timer_done;

    assign count_all_ones = &count_in;

`ifdef FREQUENCY_GATE_SEQUENCER_AUTORANGE_EN
    localparam logic [COUNT_WIDTH-1:0] LOW_THRESHOLD_C = COUNT_WIDTH'(LOW_THRESHOLD);

    // The range only moves at LATCH, from the count just measured.
    assign start_range = active_range;

    // Step to a shorter gate on overflow, a longer one on a weak count.
    always_comb begin
        auto_next_range = active_range;
        if (count_all_ones && (active_range != RANGE_0)) begin
            auto_next_range = active_range - 2'd1;
        end else if ((count_in < LOW_THRESHOLD_C) && (active_range != RANGE_2)) begin
            auto_next_range = active_range + 2'd1;
        end
    end
`else
    assign start_range     = clamp_range(range_sel);
    assign auto_next_range = active_range;
`endif

    // Reload the interval timer on every edge that enters CLEAR, GATE or SETTLE.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    timer_load  = 1'b1;
                    timer_value = tcount_t'(CLEAR_CYCLES);
                end
            end
            ST_CLEAR: begin
                if (run && timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = gate_length(active_range);
                end
            end
            ST_GATE: begin
                if (run && timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = tcount_t'(SETTLE_CYCLES);
                end
            end
            ST_HOLD: begin
                if (result_ack && run) begin
                    timer_load  = 1'b1;
                    timer_value = tcount_t'(CLEAR_CYCLES);
                end
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    frequency_gate_sequencer_gate_timer #(
        .WIDTH(TIMER_WIDTH)
    ) u_gate_timer (
        .reference_clock(reference_clock),
        .reset          (reset),
        .load           (timer_load),
        .load_value     (timer_value),
        .done           (timer_done)
    );

    // Measurement sequence; every output is set on the edge that enters its state.
    always_ff @(posedge reference_clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            active_range    <= RANGE_2;
            gate            <= 1'b0;
            clear_strobe    <= 1'b0;
            latch_strobe    <= 1'b0;
            result          <= '0;
            result_valid    <= 1'b0;
            result_range    <= RANGE_0;
            result_overflow <= 1'b0;
            dp              <= DP_RANGE_2;
            busy            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state        <= ST_CLEAR;
                        active_range <= start_range;
                        clear_strobe <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!run) begin
                        state        <= ST_IDLE;
                        clear_strobe <= 1'b0;
                        busy         <= 1'b0;
                    end else if (timer_done) begin
                        state        <= ST_GATE;
                        clear_strobe <= 1'b0;
                        gate         <= 1'b1;
                    end
                end
                ST_GATE: begin
                    if (!run) begin
                        state <= ST_IDLE;
                        gate  <= 1'b0;
                        busy  <= 1'b0;
                    end else if (timer_done) begin
                        state <= ST_SETTLE;
                        gate  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (!run) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (timer_done) begin
                        state        <= ST_LATCH;
                        latch_strobe <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    state           <= ST_HOLD;
                    latch_strobe    <= 1'b0;
                    result          <= count_in;
                    result_range    <= active_range;
                    result_overflow <= count_all_ones;
                    result_valid    <= 1'b1;
                    dp              <= dp_mask(active_range);
                    active_range    <= auto_next_range;
                end
                ST_HOLD: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        if (run) begin
                            state        <= ST_CLEAR;
                            active_range <= start_range;
                            clear_strobe <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    gate         <= 1'b0;
                    clear_strobe <= 1'b0;
                    latch_strobe <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frequency_gate_sequencer.sv
// tb/tb_frequency_gate_sequencer.sv - scoreboard bench for frequency_gate_sequencer
module tb_frequency_gate_sequencer;

    localparam int CW     = 16;
    localparam int CLEAR  = 2;
    localparam int SETTLE = 3;
    localparam int LOW    = 50;

    logic          reference_clock;
    logic          reset;
    logic          run;
    logic [1:0]    range_sel;
    logic [CW-1:0] count_in;
    logic          result_ack;
    logic          gate;
    logic          clear_strobe;
    logic          latch_strobe;
    logic [CW-1:0] result;
    logic          result_valid;
    logic [1:0]    result_range;
    logic          result_overflow;
    logic [7:0]    dp;
    logic          busy;

    frequency_gate_sequencer #(
        .COUNT_WIDTH  (CW),
        .GATE_CYCLES_0(10),
        .GATE_CYCLES_1(100),
        .GATE_CYCLES_2(1000),
        .CLEAR_CYCLES (CLEAR),
        .SETTLE_CYCLES(SETTLE),
        .LOW_THRESHOLD(LOW)
    ) dut (
        .reference_clock(reference_clock),
        .reset          (reset),
        .run            (run),
        .range_sel      (range_sel),
        .count_in       (count_in),
        .result_ack     (result_ack),
        .gate           (gate),
        .clear_strobe   (clear_strobe),
        .latch_strobe   (latch_strobe),
        .result         (result),
        .result_valid   (result_valid),
        .result_range   (result_range),
        .result_overflow(result_overflow),
        .dp             (dp),
        .busy           (busy)
    );

    initial begin
        reference_clock = 1'b0;
        forever #5 reference_clock = ~reference_clock;
    end

    typedef struct {
        int            gate_len;
        logic [CW-1:0] value;
        logic [1:0]    range;
        logic          ovf;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic [1:0]    m_range = 2'd2;
    logic [CW-1:0] m_last = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int gate_len_of(input logic [1:0] r);
        return (r == 2'd0) ? 10 : (r == 2'd1) ? 100 : 1000;
    endfunction

    function automatic logic [7:0] dp_of(input logic [1:0] r);
        return (r == 2'd0) ? 8'h10 : (r == 2'd1) ? 8'h20 : 8'h40;
    endfunction

    task automatic step();
        @(posedge reference_clock);
        #1;
    endtask

    // Reference model: decide the range a new measurement will use and queue its outcome.
    task automatic start_measure(input logic [1:0] rs, input logic [CW-1:0] v);
        exp_t e;
        logic [1:0] r;
`ifdef FREQUENCY_GATE_SEQUENCER_AUTORANGE_EN
        r = m_range;
`else
        r = (rs == 2'd3) ? 2'd2 : rs;
`endif
        e.gate_len = gate_len_of(r);
        e.value    = v;
        e.range    = r;
        e.ovf      = (v == {CW{1'b1}});
        exp_q.push_back(e);
        range_sel = rs;
        count_in  = v;
        m_last    = v;
`ifdef FREQUENCY_GATE_SEQUENCER_AUTORANGE_EN
        if (e.ovf && m_range != 2'd0) m_range = m_range - 2'd1;
        else if (v < LOW && m_range != 2'd2) m_range = m_range + 2'd1;
`endif
    endtask

    function automatic logic [CW-1:0] rand_value();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return {CW{1'b1}};
        if (sel == 1) return CW'($urandom_range(0, LOW - 1));
        return CW'($urandom_range(0, 65534));
    endfunction

    task automatic wait_valid(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    // Monitor: measure strobe/gate run lengths and compare each delivered result with the queue.
    int   clr_run = 0, clr_last = 0, gate_run = 0, gate_last = 0, gap = 0;
    bit   prev_clear = 0, prev_gate = 0, prev_valid = 0, have_cur = 0;
    exp_t cur;

    always @(negedge reference_clock) begin
        if (reset) begin
            clr_run = 0; gate_run = 0; gap = 0; have_cur = 0;
            prev_clear = 0; prev_gate = 0; prev_valid = 0;
        end else begin
            if (latch_strobe) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_latch", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    check("clear_len", clr_last, CLEAR);
                    check("gate_len", gate_last, cur.gate_len);
                    check("settle_len", gap, SETTLE);
                end
            end
            if (result_valid && !prev_valid) begin
                if (!have_cur) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("result", result, cur.value);
                    check("result_range", result_range, cur.range);
                    check("result_overflow", result_overflow, cur.ovf);
                    check("dp", dp, dp_of(cur.range));
                    check("latch_one_cycle", latch_strobe, 0);
                    have_cur = 0;
                end
            end
            if (clear_strobe) begin
                clr_run  = prev_clear ? clr_run + 1 : 1;
                clr_last = clr_run;
            end
            if (gate) begin
                gate_run  = prev_gate ? gate_run + 1 : 1;
                gate_last = gate_run;
                gap       = 0;
            end else begin
                gap++;
            end
            prev_clear = clear_strobe;
            prev_gate  = gate;
            prev_valid = result_valid;
        end
    end

    initial begin
        int gl;
        int abort_at;
        bit seen;
        reset = 1'b1; run = 1'b0; range_sel = 2'd0; count_in = '0; result_ack = 1'b0;
        repeat (3) step();
        check("rst_gate", gate, 0);
        check("rst_clear", clear_strobe, 0);
        check("rst_latch", latch_strobe, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_range", result_range, 0);
        check("rst_ovf", result_overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_dp", dp, 8'h40);
        reset = 1'b0;
        step();

        // Directed: range 1, count 12345, then a long hold before acking.
        start_measure(2'd1, CW'(12345));
        run = 1'b1;
        wait_valid(3000);
        for (int i = 0; i < 50; i++) begin
            check("hold_valid", result_valid, 1);
            check("hold_gate", gate, 0);
            check("hold_clear", clear_strobe, 0);
            check("hold_result", result, m_last);
            step();
        end
        start_measure(2'($urandom_range(0, 3)), rand_value());
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        check("ack_valid_drop", result_valid, 0);
        check("ack_clear_start", clear_strobe, 1);

        // Randomized continuous measurements.
        for (int n = 0; n < 10; n++) begin
            wait_valid(3000);
            repeat ($urandom_range(0, 4)) step();
            if (n != 9) start_measure(2'($urandom_range(0, 3)), rand_value());
            else run = 1'b0;
            result_ack = 1'b1;
            step();
            result_ack = 1'b0;
            check("ack_valid_low", result_valid, 0);
        end
        check("idle_busy", busy, 0);
        step();

        // Abort during the gate.
`ifdef FREQUENCY_GATE_SEQUENCER_AUTORANGE_EN
        gl = gate_len_of(m_range);
`else
        gl = 100;
`endif
        abort_at = (gl > 40) ? 40 : gl / 2;
        range_sel = 2'd1;
        count_in  = CW'(777);
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (gate) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("abort_gate_seen", seen, 1);
        repeat (abort_at - 1) step();
        run = 1'b0;
        step();
        check("abort_gate_low", gate, 0);
        check("abort_busy", busy, 0);
        check("abort_clear", clear_strobe, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (latch_strobe) seen = 1'b1;
            step();
        end
        check("abort_no_latch", seen, 0);
        check("abort_result_kept", result, m_last);
        check("abort_no_valid", result_valid, 0);

        // Reset while holding a result.
        start_measure(2'($urandom_range(0, 3)), rand_value());
        run = 1'b1;
        wait_valid(3000);
        step();
        reset = 1'b1;
        step();
        check("rstmid_valid", result_valid, 0);
        check("rstmid_result", result, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_dp", dp, 8'h40);
        check("rstmid_range", result_range, 0);
        reset = 1'b0;
        run = 1'b0;
        m_range = 2'd2;
        m_last = '0;
        exp_q.delete();
        step();

        // Recovery measurement from IDLE.
        start_measure(2'd0, CW'(5));
        run = 1'b1;
        wait_valid(3000);
        run = 1'b0;
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        check("final_busy", busy, 0);
        check("final_valid", result_valid, 0);
        check("queue_drained", exp_q.size(), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
